// File: rtl/rtc_reader.sv
// Read sequencer for a multiplexed Intel-style RTC bus.
// On a start edge it reads seconds, minutes and hours, then pulses listo.
module rtc_reader #(
  parameter int             BUS      = 8,
  parameter logic [BUS-1:0] ADDR_SEG = 8'h21,
  parameter logic [BUS-1:0] ADDR_MIN = 8'h22,
  parameter logic [BUS-1:0] ADDR_HOR = 8'h23
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inicio,
  input  logic [BUS-1:0] dato_in,
  output logic [BUS-1:0] dato_out,
  output logic           bus_oe,
  output logic           CS,
  output logic           RD,
  output logic           WR,
  output logic           AD,
  output logic [BUS-1:0] seg,
  output logic [BUS-1:0] min,
  output logic [BUS-1:0] hor,
  output logic           ocupado,
  output logic           listo
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [BUS-1:0] BUS_REL = {BUS{1'b1}};

  state_t         state_q, state_d;
  logic [5:0]     c_q, c_d;
  logic [1:0]     idx_q, idx_d;
  logic           ini_q;
  logic           cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d;
  logic           oe_q, oe_d, listo_q, listo_d;
  logic [BUS-1:0] dout_q, dout_d;
  logic [BUS-1:0] seg_q, seg_d, min_q, min_d, hor_q, hor_d;
  logic [BUS-1:0] addr;

  always_comb begin
    unique case (idx_q)
      2'd1:    addr = ADDR_MIN;
      2'd2:    addr = ADDR_HOR;
      default: addr = ADDR_SEG;
    endcase
  end

  // ini_q comes out of reset high so an inicio held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      idx_q   <= '0;
      ini_q   <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= BUS_REL;
      listo_q <= 1'b0;
      seg_q   <= '0;
      min_q   <= '0;
      hor_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      ini_q   <= inicio;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      listo_q <= listo_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hor_q   <= hor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    idx_d   = idx_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ad_d    = ad_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    listo_d = 1'b0;
    seg_d   = seg_q;
    min_d   = min_q;
    hor_d   = hor_q;
    unique case (state_q)
      S_IDLE: begin
        c_d    = '0;
        idx_d  = '0;
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        ad_d   = 1'b1;
        oe_d   = 1'b0;
        dout_d = BUS_REL;
        if (inicio && !ini_q) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (c_q == 6'd40) begin
          c_d = '0;
          if (idx_q == 2'd2) begin
            idx_d   = '0;
            state_d = S_IDLE;
            listo_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          c_d = c_q + 6'd1;
        end
        // Actions keyed on the step value being entered at this edge.
        case (c_d)
          6'd0: begin
            cs_d = 1'b1;
            rd_d = 1'b1;
            wr_d = 1'b1;
            ad_d = 1'b1;
          end
          6'd1:  ad_d = 1'b0;
          6'd2:  cs_d = 1'b0;
          6'd3:  wr_d = 1'b0;
          6'd4: begin
            dout_d = addr;
            oe_d   = 1'b1;
          end
          6'd9:  wr_d = 1'b1;
          6'd10: cs_d = 1'b1;
          6'd11: ad_d = 1'b1;
          6'd13: begin
            oe_d   = 1'b0;
            dout_d = BUS_REL;
          end
          6'd21: cs_d = 1'b0;
          6'd22: rd_d = 1'b0;
          6'd28: begin
            unique case (idx_q)
              2'd1:    min_d = dato_in;
              2'd2:    hor_d = dato_in;
              default: seg_d = dato_in;
            endcase
          end
          6'd29: rd_d = 1'b1;
          6'd30: cs_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dato_out = dout_q;
  assign bus_oe   = oe_q;
  assign CS       = cs_q;
  assign RD       = rd_q;
  assign WR       = wr_q;
  assign AD       = ad_q;
  assign seg      = seg_q;
  assign min      = min_q;
  assign hor      = hor_q;
  assign ocupado  = (state_q == S_BUSY);
  assign listo    = listo_q;

endmodule

// File: tb/tb_rtc_reader.sv
// Bench for rtc_reader: RTC bus model plus a timeline-based reference of
// the expected pin waveform and captured bytes, checked every cycle.
module tb_rtc_reader;
  logic       clk = 1'b0, reset = 1'b1, inicio = 1'b0;
  logic [7:0] dato_in, dato_out, seg, min, hor;
  logic       bus_oe, CS, RD, WR, AD, ocupado, listo;

  always #5 clk = ~clk;

  rtc_reader dut (
    .clk(clk), .reset(reset), .inicio(inicio), .dato_in(dato_in),
    .dato_out(dato_out), .bus_oe(bus_oe), .CS(CS), .RD(RD), .WR(WR), .AD(AD),
    .seg(seg), .min(min), .hor(hor), .ocupado(ocupado), .listo(listo)
  );

  // RTC device: latches the address on the WR rising edge, returns data while RD is low.
  logic [7:0] rtc_mem [256];
  logic [7:0] rtc_addr = 8'h00;
  logic [7:0] junk = 8'h00;
  assign dato_in = !RD ? rtc_mem[rtc_addr] : junk;
  always @(posedge WR) if (bus_oe === 1'b1) rtc_addr = dato_out;

  int checks = 0, passes = 0;
  int cyc = 0, pulses = 0, last_listo_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: position in the 123-step read timeline, t = 41*register + step.
  bit         m_busy = 0, m_listo = 0, m_prev = 1;
  int         m_t = 0;
  logic [7:0] m_reg [3] = '{default: 8'h00};
  bit         rst_s = 1, ini_s = 0;

  always @(negedge clk) begin
    rst_s = reset;
    ini_s = inicio;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_s) begin
      m_busy = 0; m_t = 0; m_listo = 0; m_prev = 1;
      m_reg = '{default: 8'h00};
    end else begin
      m_listo = 0;
      if (m_busy) begin
        if (m_t == 122) begin
          m_busy = 0; m_listo = 1;
        end else begin
          m_t++;
          if (m_t % 41 == 28) m_reg[m_t / 41] = rtc_mem[8'h21 + m_t / 41];
        end
      end else if (ini_s && !m_prev) begin
        m_busy = 1; m_t = 0;
      end
      m_prev = ini_s;
    end
  end

  function automatic logic [38:0] expect_v();
    int c, k;
    logic cs, rd, wr, ad, oe;
    logic [7:0] d;
    cs = 1; rd = 1; wr = 1; ad = 1; oe = 0; d = 8'hFF;
    if (m_busy) begin
      c  = m_t % 41;
      k  = m_t / 41;
      ad = !(c >= 1 && c <= 10);
      cs = !((c >= 2 && c <= 9) || (c >= 21 && c <= 29));
      wr = !(c >= 3 && c <= 8);
      rd = !(c >= 22 && c <= 28);
      oe = (c >= 4 && c <= 12);
      d  = oe ? 8'(8'h21 + k) : 8'hFF;
    end
    return {cs, rd, wr, ad, oe, m_busy, m_listo, d, m_reg[0], m_reg[1], m_reg[2]};
  endfunction

  always @(negedge clk) begin
    junk = 8'($urandom);
    chk("outputs", {CS, RD, WR, AD, bus_oe, ocupado, listo, dato_out, seg, min, hor}, expect_v());
    chk("oe_while_rd", !(bus_oe && !RD), 1);
    chk("rd_wr_overlap", !(!RD && !WR), 1);
    if (listo === 1'b1) begin
      pulses++;
      last_listo_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((m_busy || ocupado !== 1'b0) && n < max) begin step(); n++; end
    chk("idle_bound", n < max, 1);
    repeat (3) step();
  endtask

  task automatic wait_t(input int tt);
    int n = 0;
    while (!(m_busy && m_t == tt) && n < 300) begin step(); n++; end
    chk("step_bound", n < 300, 1);
  endtask

  task automatic pulse(input int width);
    inicio = 1'b1;
    repeat (width) step();
    inicio = 1'b0;
  endtask

  task automatic rand_mem();
    for (int a = 8'h21; a <= 8'h23; a++) rtc_mem[a] = 8'($urandom);
  endtask

  initial begin
    int t0;
    foreach (rtc_mem[i]) rtc_mem[i] = 8'($urandom);
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    chk("idle_pins", {CS, RD, WR, AD, bus_oe}, 5'b11110);
    chk("idle_dout", dato_out, 8'hFF);
    chk("idle_regs", {seg, min, hor, listo}, 25'h0);

    // Fixed values: latency and captured bytes pinned by hand.
    rtc_mem[8'h21] = 8'h45; rtc_mem[8'h22] = 8'h30; rtc_mem[8'h23] = 8'h12;
    pulses = 0;
    inicio = 1'b1;
    t0 = cyc;
    repeat (3) step();
    inicio = 1'b0;
    wait_idle(300);
    chk("latency", last_listo_cyc - t0, 124);
    chk("pulses_basic", pulses, 1);
    chk("seg_lit", seg, 8'h45);
    chk("min_lit", min, 8'h30);
    chk("hor_lit", hor, 8'h12);
    chk("ocupado_after", ocupado, 0);

    // Start edge mid-sequence is ignored.
    rand_mem(); pulses = 0;
    pulse(2);
    wait_t(41 + 15);
    pulse(2);
    wait_idle(300);
    chk("pulses_ignored", pulses, 1);
    chk("regs_ignored", {seg, min, hor}, {rtc_mem[8'h21], rtc_mem[8'h22], rtc_mem[8'h23]});

    // Reset during the hours read.
    rand_mem(); pulses = 0;
    pulse(1);
    wait_t(82 + 25);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_regs", {seg, min, hor}, 24'h0);
    chk("rst_pins", {CS, RD, WR, AD, bus_oe, ocupado}, 6'b111100);
    repeat (5) step();
    chk("rst_no_listo", pulses, 0);
    pulse(1);
    wait_idle(300);
    chk("pulses_after_rst", pulses, 1);
    chk("regs_after_rst", {seg, min, hor}, {rtc_mem[8'h21], rtc_mem[8'h22], rtc_mem[8'h23]});

    // inicio held through reset does not start.
    pulses = 0;
    inicio = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (50) step();
    chk("held_rst_pulses", pulses, 0);
    chk("held_rst_busy", ocupado, 0);
    inicio = 1'b0;
    repeat (3) step();

    // Held high: exactly one sequence.
    rand_mem(); pulses = 0;
    pulse(500);
    wait_idle(300);
    chk("pulses_held", pulses, 1);

    // Random sequences.
    for (int i = 0; i < 4; i++) begin
      rand_mem(); pulses = 0;
      repeat ($urandom_range(0, 10)) step();
      pulse($urandom_range(1, 5));
      wait_idle(300);
      chk("pulses_rand", pulses, 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
